// File: rtl/wdog_pkg.sv
`default_nettype none
// ============================================================================
// Module  : wdog_pkg
// Brief   : Shared watchdog types and ns-to-cycle conversion helper.
// Revision: 1.0 - initial release
// ============================================================================
package wdog_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ASSERT  = 2'd1,
        ST_HOLD    = 2'd2,
        ST_RELEASE = 2'd3
    } wdog_state_t;

    // 64-bit product so large ns*Hz values do not overflow before the divide.
    function automatic logic [31:0] ns_to_cycles(input logic [63:0] ns,
                                                 input logic [63:0] freq_hz);
        logic [63:0] prod;
        logic [63:0] quot;
        prod = ns * freq_hz;
        quot = prod / 64'd1000000000;
        return quot[31:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/wdog_reset_seq.sv
`default_nettype none
// ============================================================================
// Module  : wdog_reset_seq
// Brief   : Turns a watchdog kick level into ordered, staged reset releases.
// Revision: 1.0 - initial release
// ============================================================================
module wdog_reset_seq
    import wdog_pkg::*;
#(
    parameter int P_CLK_FREQ_HZ = 100000000,
    parameter int P_HOLD_NS     = 1000,
    parameter int P_STAGE_NS    = 500,
    parameter int P_N_STAGES    = 4,
    parameter int P_EVT_CNT_W   = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   kick,
    input  logic                   evt_clr,
    output logic [P_N_STAGES-1:0]  rst_stage,
    output logic                   seq_busy,
    output logic [P_EVT_CNT_W-1:0] evt_cnt
);

    localparam logic [31:0] L_HOLD_CNT  = ns_to_cycles(64'(P_HOLD_NS), 64'(P_CLK_FREQ_HZ));
    localparam logic [31:0] L_STAGE_CNT = ns_to_cycles(64'(P_STAGE_NS), 64'(P_CLK_FREQ_HZ));
    localparam int          STG_W       = $clog2(P_N_STAGES) + 1;

    localparam logic [STG_W-1:0]       c_last_stg = STG_W'(P_N_STAGES - 1);
    localparam logic [P_EVT_CNT_W-1:0] c_evt_max  = '1;

    wdog_state_t            r_state;
    wdog_state_t            w_state_nxt;
    logic [31:0]            r_cnt;
    logic [31:0]            w_cnt_nxt;
    logic [STG_W-1:0]       r_stg;
    logic [STG_W-1:0]       w_stg_nxt;
    logic [P_N_STAGES-1:0]  r_stage;
    logic [P_N_STAGES-1:0]  w_stage_nxt;
    logic                   r_busy;
    logic                   w_busy_nxt;
    logic [P_EVT_CNT_W-1:0] r_evt;
    logic [P_EVT_CNT_W-1:0] w_evt_nxt;
    logic                   r_kick_d;
    logic                   w_kick_rise;

    // Reset lands in HOLD so power-up runs the same ordered release as a kick.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ST_HOLD;
            r_cnt    <= '0;
            r_stg    <= '0;
            r_stage  <= '1;
            r_busy   <= 1'b1;
            r_evt    <= '0;
            r_kick_d <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_stg    <= w_stg_nxt;
            r_stage  <= w_stage_nxt;
            r_busy   <= w_busy_nxt;
            r_evt    <= w_evt_nxt;
            r_kick_d <= kick;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_stg_nxt   = r_stg;
        w_stage_nxt = r_stage;
        w_busy_nxt  = r_busy;

        case (r_state)
            ST_IDLE: begin
                w_stage_nxt = '0;
                w_busy_nxt  = 1'b0;
                if (kick) begin
                    w_state_nxt = ST_ASSERT;
                    w_stage_nxt = '1;
                    w_busy_nxt  = 1'b1;
                end
            end
            ST_ASSERT: begin
                w_stage_nxt = '1;
                w_busy_nxt  = 1'b1;
                if (!kick) begin
                    w_state_nxt = ST_HOLD;
                    w_cnt_nxt   = '0;
                end
            end
            ST_HOLD: begin
                if (kick) begin
                    w_state_nxt = ST_ASSERT;
                    w_stage_nxt = '1;
                    w_cnt_nxt   = '0;
                    w_stg_nxt   = '0;
                end else if (r_cnt == L_HOLD_CNT) begin
                    w_state_nxt    = ST_RELEASE;
                    w_stage_nxt[0] = 1'b0;
                    w_stg_nxt      = STG_W'(1);
                    w_cnt_nxt      = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 32'd1;
                end
            end
            ST_RELEASE: begin
                if (kick) begin
                    w_state_nxt = ST_ASSERT;
                    w_stage_nxt = '1;
                    w_cnt_nxt   = '0;
                    w_stg_nxt   = '0;
                end else if (r_cnt == L_STAGE_CNT) begin
                    for (int i = 0; i < P_N_STAGES; i++) begin
                        if (r_stg == STG_W'(i)) begin
                            w_stage_nxt[i] = 1'b0;
                        end
                    end
                    w_stg_nxt = r_stg + STG_W'(1);
                    w_cnt_nxt = '0;
                    if (r_stg == c_last_stg) begin
                        w_state_nxt = ST_IDLE;
                        w_busy_nxt  = 1'b0;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 32'd1;
                end
            end
            default: begin
                w_state_nxt = ST_HOLD;
            end
        endcase
    end

    // A clear coinciding with a new kick still records that kick.
    always_comb begin
        w_kick_rise = kick & ~r_kick_d;
        w_evt_nxt   = r_evt;
        if (evt_clr) begin
            w_evt_nxt = P_EVT_CNT_W'(w_kick_rise);
        end else if (w_kick_rise && (r_evt != c_evt_max)) begin
            w_evt_nxt = r_evt + P_EVT_CNT_W'(1);
        end
    end

    assign rst_stage = r_stage;
    assign seq_busy  = r_busy;
    assign evt_cnt   = r_evt;

endmodule
`default_nettype wire

// File: tb/tb_wdog_reset_seq.sv
`default_nettype none
// ============================================================================
// Module  : tb_wdog_reset_seq
// Brief   : Self-checking bench; default and zero-timing/2-bit-counter DUTs.
// Revision: 1.0 - initial release
// ============================================================================
module tb_wdog_reset_seq;

    localparam int FREQ = 100000000;

    logic        clk;
    logic        rst;
    logic        kick;
    logic        evt_clr;
    logic [3:0]  stage_a;
    logic        busy_a;
    logic [15:0] evt_a;
    logic [3:0]  stage_b;
    logic        busy_b;
    logic [1:0]  evt_b;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    wdog_reset_seq #(
        .P_CLK_FREQ_HZ(FREQ), .P_HOLD_NS(1000), .P_STAGE_NS(500),
        .P_N_STAGES(4), .P_EVT_CNT_W(16)
    ) u_dut_a (
        .clk(clk), .rst(rst), .kick(kick), .evt_clr(evt_clr),
        .rst_stage(stage_a), .seq_busy(busy_a), .evt_cnt(evt_a)
    );

    wdog_reset_seq #(
        .P_CLK_FREQ_HZ(FREQ), .P_HOLD_NS(0), .P_STAGE_NS(0),
        .P_N_STAGES(4), .P_EVT_CNT_W(2)
    ) u_dut_b (
        .clk(clk), .rst(rst), .kick(kick), .evt_clr(evt_clr),
        .rst_stage(stage_b), .seq_busy(busy_b), .evt_cnt(evt_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int unsigned cyc(input longint ns);
        return int'((ns * longint'(FREQ)) / 64'sd1000000000);
    endfunction

    // Per-instance timing: index 0 = default DUT, 1 = zero-timing DUT.
    int unsigned m_h   [2];
    int unsigned m_s   [2];
    int unsigned m_max [2];
    initial begin
        m_h[0] = cyc(1000); m_s[0] = cyc(500); m_max[0] = 65535;
        m_h[1] = cyc(0);    m_s[1] = cyc(0);   m_max[1] = 3;
    end

    // Number of stages released e cycles after the hold phase began.
    function automatic int unsigned released(input int unsigned e,
                                             input int unsigned h,
                                             input int unsigned s);
        int unsigned r;
        if (e < h + 1) return 0;
        r = 1 + (e - h - 1) / (s + 1);
        return (r > 4) ? 4 : r;
    endfunction

    // mode: 0 = all released, 1 = kick held, 2 = hold/release timeline running
    int          m_mode [2];
    int unsigned m_e    [2];
    int unsigned m_evt  [2];
    logic        m_kprev;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                m_mode[i] <= 2;
                m_e[i]    <= 0;
                m_evt[i]  <= 0;
            end
            m_kprev <= 1'b0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (kick) begin
                    m_mode[i] <= 1;
                end else if (m_mode[i] == 1) begin
                    m_mode[i] <= 2;
                    m_e[i]    <= 0;
                end else if (m_mode[i] == 2) begin
                    m_e[i] <= m_e[i] + 1;
                    if (released(m_e[i] + 1, m_h[i], m_s[i]) >= 4) m_mode[i] <= 0;
                end
                if (evt_clr) begin
                    m_evt[i] <= (kick && !m_kprev) ? 1 : 0;
                end else if (kick && !m_kprev && m_evt[i] < m_max[i]) begin
                    m_evt[i] <= m_evt[i] + 1;
                end
            end
            m_kprev <= kick;
        end
    end

    function automatic logic [3:0] exp_stage(input int i);
        if (m_mode[i] == 1) return 4'hF;
        if (m_mode[i] == 0) return 4'h0;
        return 4'hF << released(m_e[i], m_h[i], m_s[i]);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("a_stage", 32'(stage_a), 32'(exp_stage(0)));
            chk("a_busy",  32'(busy_a),  32'(m_mode[0] != 0));
            chk("a_evt",   32'(evt_a),   m_evt[0]);
            chk("b_stage", 32'(stage_b), 32'(exp_stage(1)));
            chk("b_busy",  32'(busy_b),  32'(m_mode[1] != 0));
            chk("b_evt",   32'(evt_b),   m_evt[1]);
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic run_rand(input int n, input logic k);
        for (int c = 0; c < n; c++) begin
            kick    = k;
            evt_clr = ($urandom_range(0, 15) == 0);
            step(1);
        end
        evt_clr = 1'b0;
    endtask

    initial begin
        rst = 1'b0; kick = 1'b0; evt_clr = 1'b0;
        #1 rst = 1'b1;
        step(1);
        chk_en = 1'b1;
        chk("rst_stage_a", 32'(stage_a), 32'hF);
        chk("rst_evt_a",   32'(evt_a),   32'h0);
        step(2);
        rst = 1'b0;

        // power-on release
        step(1);
        chk("po_b_1", 32'(stage_b), 32'hE);
        chk("po_a_1", 32'(stage_a), 32'hF);
        step(3);
        chk("po_b_4", 32'(stage_b), 32'h0);
        chk("po_b_busy", 32'(busy_b), 32'h0);
        step(96);
        chk("po_a_100", 32'(stage_a), 32'hF);
        step(1);
        chk("po_a_101", 32'(stage_a), 32'hE);
        step(51);
        chk("po_a_152", 32'(stage_a), 32'hC);
        step(51);
        chk("po_a_203", 32'(stage_a), 32'h8);
        chk("po_a_busy203", 32'(busy_a), 32'h1);
        step(51);
        chk("po_a_254", 32'(stage_a), 32'h0);
        chk("po_a_busy254", 32'(busy_a), 32'h0);

        // kick from idle, 200 cycles
        kick = 1'b1;
        step(1);
        chk("kick_a_assert", 32'(stage_a), 32'hF);
        chk("kick_a_evt", 32'(evt_a), 32'h1);
        step(199);
        kick = 1'b0;
        step(101);
        chk("kick_a_hold", 32'(stage_a), 32'hF);
        step(1);
        chk("kick_a_rel0", 32'(stage_a), 32'hE);
        step(51);
        chk("kick_a_rel1", 32'(stage_a), 32'hC);

        // kick during release
        kick = 1'b1;
        step(1);
        chk("rekick_a", 32'(stage_a), 32'hF);
        chk("rekick_evt", 32'(evt_a), 32'h2);
        kick = 1'b0;
        step(300);
        chk("rekick_done", 32'(busy_a), 32'h0);

        // saturation and clear
        for (int p = 0; p < 5; p++) begin
            kick = 1'b1; step(1);
            kick = 1'b0; step(2);
        end
        chk("sat_b", 32'(evt_b), 32'h3);
        chk("sat_a", 32'(evt_a), 32'h7);
        kick = 1'b1; evt_clr = 1'b1;
        step(1);
        chk("clr_rise_b", 32'(evt_b), 32'h1);
        chk("clr_rise_a", 32'(evt_a), 32'h1);
        kick = 1'b0; evt_clr = 1'b0;
        step(2);
        evt_clr = 1'b1;
        step(1);
        evt_clr = 1'b0;
        chk("clr_b", 32'(evt_b), 32'h0);
        chk("clr_a", 32'(evt_a), 32'h0);
        step(300);

        // randomized kicks and clears
        for (int it = 0; it < 40; it++) begin
            run_rand(int'($urandom_range(1, 4)), 1'b1);
            run_rand(int'($urandom_range(1, 350)), 1'b0);
        end
        kick = 1'b0;
        step(300);

        // asynchronous reset in the middle of HOLD
        kick = 1'b1; step(2);
        kick = 1'b0; step(20);
        chk("pre_arst_b", 32'(stage_b), 32'h0);
        #2 rst = 1'b1;
        #1;
        chk("arst_a", 32'(stage_a), 32'hF);
        chk("arst_b", 32'(stage_b), 32'hF);
        step(2);
        rst = 1'b0;
        step(1);
        chk("arst_b_1", 32'(stage_b), 32'hE);
        step(99);
        chk("arst_a_100", 32'(stage_a), 32'hF);
        step(1);
        chk("arst_a_101", 32'(stage_a), 32'hE);
        step(200);

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/wdog_reset_seq.md
Name: wdog_reset_seq

Overview:
- Consumer end of the watchdog kick interface: takes the watchdog's level-high `kick` and turns it into a staged, ordered set of active-high reset outputs.
- Holds all stages in reset while kick is high and for a minimum hold time after it drops, then releases stages one at a time with a fixed gap.
- Counts kick events in a saturating counter for status readback.
- Sits between the watchdog and the per-subsystem reset nets, in the same clock domain as the watchdog.

Parameters:
- P_CLK_FREQ_HZ, 100000000, clock frequency used for ns-to-cycle conversion.
- P_HOLD_NS, 1000, minimum all-stage reset hold after kick deasserts.
- P_STAGE_NS, 500, gap between successive stage releases.
- P_N_STAGES, 4, number of reset outputs (2..16).
- P_EVT_CNT_W, 16, width of the kick event counter.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- kick  in  1  watchdog kick level, synchronous to clk.
- evt_clr  in  1  synchronous clear of evt_cnt.
- rst_stage  out  P_N_STAGES  active-high stage resets; bit 0 is released first.
- seq_busy  out  1  high whenever any stage is asserted.
- evt_cnt  out  P_EVT_CNT_W  saturating count of kick rising edges.

Behaviour:
- One clock domain; reset is asynchronous and active-high (`clk`, `rst`). No synchronizer is used on kick.
- Cycle constants (32-bit, integer truncation):
  - L_HOLD_CNT = P_HOLD_NS*P_CLK_FREQ_HZ/1e9 (100 at defaults).
  - L_STAGE_CNT = P_STAGE_NS*P_CLK_FREQ_HZ/1e9 (50 at defaults).
  - 64-bit intermediate arithmetic is required.
- Reset values: rst_stage = all ones, seq_busy = 1, evt_cnt = 0, kick_d = 0, state = HOLD, cnt = 0, stg = 0. Deassertion of rst therefore runs a full power-on release sequence.
- States: IDLE, ASSERT, HOLD, RELEASE. All outputs are registered.
- IDLE:
  - rst_stage = 0, seq_busy = 0.
  - kick sampled high -> ASSERT; set rst_stage = all ones and seq_busy = 1 at that edge.
- ASSERT:
  - rst_stage held all ones.
  - kick sampled low -> HOLD, cnt = 0.
- HOLD:
  - cnt increments each cycle.
  - When cnt == L_HOLD_CNT: clear rst_stage[0], stg = 1, cnt = 0, go to RELEASE.
  - HOLD therefore lasts L_HOLD_CNT+1 cycles.
- RELEASE:
  - cnt increments each cycle.
  - When cnt == L_STAGE_CNT: clear rst_stage[stg], stg++, cnt = 0.
  - If stg was P_N_STAGES-1 on that edge, go to IDLE and set seq_busy = 0 on the same edge.
- Release spacing: stage i is released (L_STAGE_CNT+1)*i cycles after stage 0. Release is monotonic; a higher stage is never released before a lower one.
- Kick high in HOLD or RELEASE: go to ASSERT on that edge; re-assert all stages; clear cnt and stg. The partial sequence is abandoned.
- Event count:
  - kick_rise = kick & ~kick_d; evt_cnt increments on kick_rise and saturates at all ones.
  - Counting happens in every state, including the post-reset HOLD.
- evt_clr and kick_rise in the same cycle: evt_cnt = 1. evt_clr alone: evt_cnt = 0.
- Zero constants: L_HOLD_CNT = 0 gives a 1-cycle HOLD; L_STAGE_CNT = 0 gives 1-cycle spacing.
- Reset mid-sequence: rst forces all stages asserted immediately (asynchronously) and restarts from HOLD.
- Counter widths: cnt is 32 bits; stg is clog2(P_N_STAGES)+1 bits.

Decomposition:
- Shared package `wdog_pkg`:
  - state enum (IDLE, ASSERT, HOLD, RELEASE);
  - constant function ns_to_cycles(ns, freq_hz) returning 32 bits, shared with the watchdog.
- Single module. No sub-module is warranted; the edge detector and counters are inline.

Test Plan:
- Power-on: deassert rst, hold kick = 0 (defaults) -> rst_stage = 4'b1111 for 101 cycles, then bits clear in order 0..3 at 51-cycle spacing; seq_busy falls with bit 3; evt_cnt = 0.
- Kick from IDLE: 200-cycle kick pulse -> all stages assert on the first sampled-high edge and stay asserted through the pulse; 101-cycle HOLD after kick falls; staged release follows; evt_cnt = 1.
- Kick during RELEASE: kick for 1 cycle right after stage 1 releases -> rst_stage returns to 4'b1111 the next edge; full HOLD+release re-runs; evt_cnt increments by 1.
- Saturation/clear: P_EVT_CNT_W = 2, five kick pulses -> evt_cnt stops at 3. Then evt_clr coincident with a kick rise -> evt_cnt = 1. Then evt_clr alone -> 0.
- Zero timing: P_HOLD_NS = 0 and P_STAGE_NS = 0 -> after kick falls, stages release on 4 consecutive edges starting one edge after HOLD entry.
- Async reset mid-HOLD: assert rst between clock edges -> rst_stage = all ones immediately without a clock edge; sequence restarts from cnt = 0 after rst deasserts.
